spi_sample_fifo: RTL
====================

SPI_SAMPLE_FIFO -- requirements
Module: spi_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter AVG_LOG2, default 2, meaning log2 of the averaging window (4 samples).
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; every flop is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 SHALL have port sbusy, input, 1 bit, the SPI master busy flag (bit 0 of the master's sbusy).
REQ-006 SHALL have ports byte_l and byte_m, inputs, 8 bits each, the low and high sample bytes from the SPI master.
REQ-007 SHALL have Wishbone slave ports wb_cyc_i (1), wb_stb_i (1), wb_we_i (1), wb_adr_i (32), wb_dat_i (32), wb_sel_i (4) as inputs, and wb_dat_o (32), wb_ack_o (1) as outputs.
REQ-008 SHALL have port irq, output, 1 bit, meaning data available.

Function
REQ-009 sbusy SHALL pass through a 2-flop synchronizer; a capture event is synced sbusy 1 then 0 in consecutive cycles (falling edge) with CTRL.en=1.
REQ-010 On a capture event, sample = {byte_m, byte_l} (16-bit two's complement) SHALL be taken in that same cycle.
REQ-011 With CTRL.avg=0, each sample SHALL be pushed directly.
REQ-012 With CTRL.avg=1, samples SHALL be sign-extended into a 20-bit accumulator; on the 2^AVG_LOG2-th sample, sum>>>AVG_LOG2 (arithmetic shift, bits [15:0]) SHALL be pushed and the accumulator and sample counter cleared.
REQ-013 Writing CTRL.avg SHALL clear the accumulator and sample counter.
REQ-014 Push-to-visible latency SHALL be 1 cycle after the capture event (STATUS.count increments then).
REQ-015 Push when full SHALL drop the entry, leave contents unchanged and set sticky STATUS.ovf.
REQ-016 Push and pop in the same cycle SHALL both take effect; count unchanged; legal even when full (no ovf) or empty with push (pop returns 0, count +1).
REQ-017 Read pointers, write pointers and count SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-018 Register map by wb_adr_i[3:2]:
  - 0 DATA (RO): read returns {16 sign bits, head entry} and pops; read when empty returns 0 and causes no state change.
  - 1 STATUS (RO): [4:0] count, [8] empty, [9] full, [10] ovf, rest 0.
  - 2 CTRL (RW): [0] en, [1] avg, [2] clr (write-1 self-clearing, reads 0).
  - 3: reads 0, writes ignored.
REQ-019 Writing clr=1 SHALL empty the FIFO, clear ovf and the accumulator the next cycle; a capture in that same cycle is discarded.
REQ-020 Wishbone: when cyc&stb&~ack, wb_ack_o SHALL assert for exactly 1 cycle on the next edge, with wb_dat_o valid in that cycle; the pop or write occurs once per ack.
REQ-021 Back-to-back strobes SHALL be acked on alternate cycles.
REQ-022 wb_sel_i SHALL be ignored; wb_dat_o SHALL be 0 when ack is low.
REQ-023 irq SHALL be registered, equal to en & ~empty, 1 cycle after the change.

Reset
REQ-024 reset=1 SHALL set: FIFO empty; pointers 0; count 0; ovf 0; CTRL = 0 (en=0, avg=0); accumulator 0; synchronizer flops 1 (no false edge); wb_ack_o 0; wb_dat_o 0; irq 0.
REQ-025 Reset mid-transaction SHALL abort it with no ack issued, and captures SHALL be ignored in the reset cycle.

Verification
REQ-026 en=1, avg=0, sbusy 1->0 with byte_m=0x12, byte_l=0x34 -> count=1 two cycles after the synchronizer; DATA read returns 0x00001234, then count=0 and irq falls.
REQ-027 byte_m/byte_l=0xFF80 captured -> DATA read returns 0xFFFFFF80.
REQ-028 avg=1, four captures of 0x0010, 0x0020, 0x0030, 0x0041 -> exactly one entry 0x0028, pushed after the fourth capture only.
REQ-029 DEPTH=8, nine captures without reads -> full=1, count=8, ovf=1, first 8 values read back in order; write CTRL=0x5 -> empty=1 and ovf=0.
REQ-030 FIFO full, DATA read acked in the same cycle as a capture -> count stays 8, ovf stays 0, new sample at the tail.
REQ-031 Read DATA when empty -> 0x00000000 with a single-cycle ack; a reset asserted during a pending strobe -> no ack and all STATUS fields 0 except empty=1.

Source files
------------

// File: rtl/spi_sample_fifo_if.sv
// rtl/spi_sample_fifo_if.sv - Wishbone register bus between a bus master and spi_sample_fifo
// Signals (named from the slave's point of view):
//   wb_cyc_i, wb_stb_i, wb_we_i : cycle, strobe, write enable
//   wb_adr_i [31:0]              : byte address, register select in [3:2]
//   wb_dat_i [31:0]              : write data
//   wb_sel_i [3:0]               : byte selects (ignored by the slave)
//   wb_dat_o [31:0]              : read data, valid while wb_ack_o is high
//   wb_ack_o                     : single-cycle acknowledge
interface spi_sample_fifo_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/spi_sample_fifo.sv
// rtl/spi_sample_fifo.sv - SPI sample capture FIFO with optional averaging and Wishbone register access
// Ports:
//   clk            : system clock, all flops on the rising edge
//   reset          : synchronous active-high reset
//   sbusy          : SPI master busy flag, asynchronous to clk
//   byte_l, byte_m : low / high sample bytes from the SPI master
//   irq            : registered data-available flag (en & ~empty)
//   wb             : Wishbone slave, registers selected by wb_adr_i[3:2]
//                    0 DATA (RO, pops), 1 STATUS (RO), 2 CTRL (RW), 3 reserved
module spi_sample_fifo #(
  parameter int DEPTH    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sbusy,
  input  logic [7:0]       byte_l,
  input  logic [7:0]       byte_m,
  output logic             irq,
  spi_sample_fifo_if.slave wb
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int AW   = AVG_LOG2 + 1;
  localparam int NAVG = 1 << AVG_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_AVG = AW'(NAVG - 1);

  // synchronizer plus one history flop for falling-edge detection
  logic sync_1, sync_2, sync_3;

  logic          en, avg;
  logic [19:0]   acc;
  logic [AW-1:0] acc_cnt;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic        req, ctrl_wr, clr, data_rd;
  logic [1:0]  reg_sel;
  logic        capture, avg_done, push, do_push, pop, ovf_set;
  logic        empty, full;
  logic [15:0] sample, push_val, head;
  logic [19:0] sample_ext, sum;
  logic signed [19:0] sum_sh;
  logic [31:0] rdata;
  logic [4:0]  count5;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign reg_sel = wb.wb_adr_i[3:2];
  assign ctrl_wr = req & wb.wb_we_i & (reg_sel == 2'd2);
  assign clr     = ctrl_wr & wb.wb_dat_i[2];
  assign data_rd = req & ~wb.wb_we_i & (reg_sel == 2'd0);

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign count5 = 5'(count);
  assign head   = mem[rd_ptr];

  assign capture    = sync_3 & ~sync_2 & en;
  assign sample     = {byte_m, byte_l};
  assign sample_ext = {{4{sample[15]}}, sample};
  assign sum        = acc + sample_ext;
  assign sum_sh     = $signed(sum) >>> AVG_LOG2;
  assign avg_done   = avg & (acc_cnt == LAST_AVG);
  assign push_val   = avg ? sum_sh[15:0] : sample;

  // a clear in flight discards any capture landing in the same cycle
  assign push    = capture & (~avg | avg_done) & ~clr;
  assign pop     = data_rd & ~empty;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign do_push = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = empty ? 32'd0 : {{16{head[15]}}, head};
      2'd1: rdata = {21'd0, ovf, full, empty, 3'd0, count5};
      2'd2: rdata = {30'd0, avg, en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      sync_3 <= 1'b1;
    end else begin
      sync_1 <= sbusy;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      en          <= 1'b0;
      avg         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= (req & ~wb.wb_we_i) ? rdata : 32'd0;
      if (ctrl_wr) begin
        en  <= wb.wb_dat_i[0];
        avg <= wb.wb_dat_i[1];
      end
      irq <= en & ~empty;
    end
  end

  // any CTRL write restarts the averaging window
  always_ff @(posedge clk) begin
    if (reset || ctrl_wr) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (capture && avg) begin
      if (avg_done) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= sum;
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= push_val;
  end

  logic unused_bits;
  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:3], sum_sh[19:16]};
endmodule
